serdesphy_rx_manchester_deframer: RTL and testbench

Receive-side counterpart of the TX Manchester encode/serialize path. Consumes the recovered serial chip stream from the analog deserializer/CDR in the RX bit-clock domain. It hunts for a Manchester-encoded sync byte to establish byte alignment, then decodes each 16-chip group to an 8-bit byte and flags code violations. Loss of lock is declared after repeated errored words. Output feeds the RX FIFO/PRBS checker via the RX CDC.

---
 rtl/serdesphy_pkg.sv | 31 +++
 rtl/serdesphy_manchester_pair_decode.sv | 24 ++
 rtl/serdesphy_rx_manchester_deframer.sv | 157 +++++++++++++++
 tb/tb_serdesphy_rx_manchester_deframer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/serdesphy_pkg.sv
//------------------------------------------------------------------------------
// Module  : serdesphy_pkg
// Brief   : Shared Manchester types, chip-pair constants and 8->16 encoder.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serdesphy_pkg;

  typedef enum logic [0:0] {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } rx_state_e;

  localparam logic [1:0] MAN_ONE           = 2'b10;
  localparam logic [1:0] MAN_ZERO          = 2'b01;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hBC;

  // Bit 7 lands in chips[15:14] so the MSB goes out on the line first.
  function automatic logic [15:0] man_encode(input logic [7:0] b);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c[2*i +: 2] = b[i] ? MAN_ONE : MAN_ZERO;
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serdesphy_manchester_pair_decode.sv
//------------------------------------------------------------------------------
// Module  : serdesphy_manchester_pair_decode
// Brief   : Combinational 16-chip to 8-bit Manchester decode with violation mask.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serdesphy_manchester_pair_decode
  import serdesphy_pkg::*;
(
  input  logic [15:0] i_chips,
  output logic [7:0]  o_data,
  output logic [7:0]  o_viol
);

  // Violation pairs ("00"/"11") decode to 0.
  for (genvar i = 0; i < 8; i++) begin : g_pair
    assign o_data[i] = (i_chips[2*i +: 2] == MAN_ONE);
    assign o_viol[i] = i_chips[2*i+1] ~^ i_chips[2*i];
  end

endmodule

`default_nettype wire

// File: rtl/serdesphy_rx_manchester_deframer.sv
//------------------------------------------------------------------------------
// Module  : serdesphy_rx_manchester_deframer
// Brief   : Hunts for the Manchester sync byte, then decodes 16-chip words and
//           tracks code violations / loss of lock. Optional macro
//           SERDESPHY_RX_SYNC_STRIP_EN suppresses clean in-lock sync bytes.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serdesphy_rx_manchester_deframer
  import serdesphy_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE  = DEFAULT_SYNC_BYTE,
  parameter int unsigned ERR_THRESH = 4
) (
  input  logic       clk_240m_rx,
  input  logic       rst_n_240m_rx,
  input  logic       rx_en,
  input  logic       rx_serial_data,
  input  logic       rx_serial_valid,
  input  logic       rx_err_clr,
  output logic [7:0] rx_word,
  output logic       rx_word_valid,
  output logic       rx_locked,
  output logic       rx_code_err,
  output logic       rx_lock_lost,
  output logic [7:0] rx_err_count
);

  localparam logic [15:0] c_SYNC_CHIPS = man_encode(SYNC_BYTE);
  localparam logic [3:0]  c_THRESH     = 4'(ERR_THRESH);

  rx_state_e   r_state;
  rx_state_e   w_state_nxt;
  logic [15:0] r_shift;
  logic [3:0]  r_chip_cnt;
  logic [3:0]  r_consec_err;
  logic [7:0]  r_word;
  logic        r_word_valid;
  logic        r_code_err;
  logic        r_lock_lost;
  logic [7:0]  r_err_count;

  logic [15:0] w_nxt;
  logic [7:0]  w_dec;
  logic [7:0]  w_viol;
  logic        w_err;
  logic        w_sync_hit;
  logic        w_word_done;
  logic        w_lose;
  logic        w_emit;
  logic        w_locked;

  assign w_nxt = {r_shift[14:0], rx_serial_data};

  serdesphy_manchester_pair_decode u_decode (
    .i_chips (w_nxt),
    .o_data  (w_dec),
    .o_viol  (w_viol)
  );

  assign w_err       = |w_viol;
  assign w_sync_hit  = rx_en && rx_serial_valid && (r_state == ST_HUNT) &&
                       (w_nxt == c_SYNC_CHIPS);
  assign w_word_done = rx_en && rx_serial_valid && (r_state == ST_LOCKED) &&
                       (r_chip_cnt == 4'd15);
  assign w_lose      = w_word_done && w_err && ((r_consec_err + 4'd1) == c_THRESH);

`ifdef SERDESPHY_RX_SYNC_STRIP_EN
  assign w_emit = w_err || (w_dec != SYNC_BYTE);
`else
  assign w_emit = 1'b1;
`endif

  always_ff @(posedge clk_240m_rx or negedge rst_n_240m_rx) begin
    if (!rst_n_240m_rx) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!rx_en) begin
      w_state_nxt = ST_HUNT;
    end else begin
      case (r_state)
        ST_HUNT:   if (w_sync_hit) w_state_nxt = ST_LOCKED;
        ST_LOCKED: if (w_lose)     w_state_nxt = ST_HUNT;
        default:   w_state_nxt = ST_HUNT;
      endcase
    end
  end

  always_comb begin
    w_locked = (r_state == ST_LOCKED);
  end

  always_ff @(posedge clk_240m_rx or negedge rst_n_240m_rx) begin
    if (!rst_n_240m_rx) begin
      r_shift      <= '0;
      r_chip_cnt   <= '0;
      r_consec_err <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_code_err   <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      r_code_err   <= 1'b0;
      r_lock_lost  <= 1'b0;
      if (!rx_en) begin
        r_shift      <= '0;
        r_chip_cnt   <= '0;
        r_consec_err <= '0;
      end else if (rx_serial_valid) begin
        r_shift <= w_nxt;
        if (r_state == ST_LOCKED) begin
          r_chip_cnt <= r_chip_cnt + 4'd1;
        end
        if (w_word_done) begin
          r_word       <= w_dec;
          r_word_valid <= w_emit;
          r_code_err   <= w_err;
          r_lock_lost  <= w_lose;
          if (!w_err || w_lose) begin
            r_consec_err <= '0;
          end else begin
            r_consec_err <= r_consec_err + 4'd1;
          end
        end
      end
    end
  end

  // Clear wins over a same-cycle increment; count survives rx_en drop.
  always_ff @(posedge clk_240m_rx or negedge rst_n_240m_rx) begin
    if (!rst_n_240m_rx) begin
      r_err_count <= '0;
    end else if (rx_err_clr) begin
      r_err_count <= '0;
    end else if (w_word_done && w_err && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign rx_word       = r_word;
  assign rx_word_valid = r_word_valid;
  assign rx_locked     = w_locked;
  assign rx_code_err   = r_code_err;
  assign rx_lock_lost  = r_lock_lost;
  assign rx_err_count  = r_err_count;

endmodule

`default_nettype wire

// File: tb/tb_serdesphy_rx_manchester_deframer.sv
//------------------------------------------------------------------------------
// Module  : tb_serdesphy_rx_manchester_deframer
// Brief   : Directed scoreboard bench for the Manchester RX deframer.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serdesphy_rx_manchester_deframer;

  logic       clk_240m_rx;
  logic       rst_n_240m_rx;
  logic       rx_en;
  logic       rx_serial_data;
  logic       rx_serial_valid;
  logic       rx_err_clr;
  logic [7:0] rx_word;
  logic       rx_word_valid;
  logic       rx_locked;
  logic       rx_code_err;
  logic       rx_lock_lost;
  logic [7:0] rx_err_count;

  typedef struct packed {
    logic [7:0] word;
    logic       code_err;
    logic       lock_lost;
  } exp_t;

  exp_t q_exp[$];
  int   n_cmp;
  int   n_fail;

  serdesphy_rx_manchester_deframer dut (
    .clk_240m_rx     (clk_240m_rx),
    .rst_n_240m_rx   (rst_n_240m_rx),
    .rx_en           (rx_en),
    .rx_serial_data  (rx_serial_data),
    .rx_serial_valid (rx_serial_valid),
    .rx_err_clr      (rx_err_clr),
    .rx_word         (rx_word),
    .rx_word_valid   (rx_word_valid),
    .rx_locked       (rx_locked),
    .rx_code_err     (rx_code_err),
    .rx_lock_lost    (rx_lock_lost),
    .rx_err_count    (rx_err_count)
  );

  initial clk_240m_rx = 1'b0;
  always #5 clk_240m_rx = ~clk_240m_rx;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every output strobe must match the oldest pushed expectation.
  always @(negedge clk_240m_rx) begin
    if (rx_word_valid === 1'b1) begin
      if (q_exp.size() == 0) begin
        check("unexpected_word", {24'd0, rx_word}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q_exp.pop_front();
        check("sb_word", {24'd0, rx_word}, {24'd0, e.word});
        check("sb_code_err", {31'd0, rx_code_err}, {31'd0, e.code_err});
        check("sb_lock_lost", {31'd0, rx_lock_lost}, {31'd0, e.lock_lost});
      end
    end
  end

  task automatic send_chip(input logic b);
    rx_serial_data  = b;
    rx_serial_valid = 1'b1;
    @(posedge clk_240m_rx);
    #1;
  endtask

  task automatic idle(input int n);
    rx_serial_valid = 1'b0;
    repeat (n) begin
      @(posedge clk_240m_rx);
      #1;
    end
  endtask

  task automatic send_word(input logic [15:0] chips);
    for (int i = 15; i >= 0; i--) send_chip(chips[i]);
    rx_serial_valid = 1'b0;
  endtask

  task automatic push(input logic [7:0] w, input logic ce, input logic ll);
    exp_t e;
    e.word = w; e.code_err = ce; e.lock_lost = ll;
    q_exp.push_back(e);
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n_240m_rx   = 1'b0;
    rx_en           = 1'b1;
    rx_serial_data  = 1'b0;
    rx_serial_valid = 1'b0;
    rx_err_clr      = 1'b0;
    repeat (3) @(posedge clk_240m_rx);
    #1;
    check("rst_locked", {31'd0, rx_locked}, 32'd0);
    check("rst_word_valid", {31'd0, rx_word_valid}, 32'd0);
    check("rst_word", {24'd0, rx_word}, 32'd0);
    check("rst_err_count", {24'd0, rx_err_count}, 32'd0);
    rst_n_240m_rx = 1'b1;
    idle(2);

    // Acquire lock on the sync pattern; the sync byte itself is not emitted.
    send_word(16'h9AA5);
    check("lock_after_sync", {31'd0, rx_locked}, 32'd1);
    check("sync_not_emitted", {31'd0, rx_word_valid}, 32'd0);

    push(8'h5A, 1'b0, 1'b0);
    send_word(16'h6699);
    check("clean_word_valid", {31'd0, rx_word_valid}, 32'd1);
    check("clean_code_err", {31'd0, rx_code_err}, 32'd0);

    push(8'h5A, 1'b1, 1'b0);
    send_word(16'h6698);
    check("viol_word_valid", {31'd0, rx_word_valid}, 32'd1);
    check("viol_err_count", {24'd0, rx_err_count}, 32'd1);
    idle(2);

    // Clean word clears the run, then four violating words lose lock.
    push(8'h5A, 1'b0, 1'b0);
    send_word(16'h6699);
    for (int k = 0; k < 4; k++) begin
      push(8'h5A, 1'b1, (k == 3));
      send_word(16'h6698);
      if (k < 3) check("still_locked", {31'd0, rx_locked}, 32'd1);
    end
    idle(1);
    check("lock_lost_unlocked", {31'd0, rx_locked}, 32'd0);
    check("err_count_5", {24'd0, rx_err_count}, 32'd5);

    // Flush stale chips before re-syncing.
    for (int i = 0; i < 16; i++) send_chip(1'b0);
    check("hunt_on_zeros", {31'd0, rx_locked}, 32'd0);
    send_word(16'h9AA5);
    check("relock", {31'd0, rx_locked}, 32'd1);

    // Stalled delivery: valid low between every chip.
    push(8'h5A, 1'b0, 1'b0);
    for (int i = 15; i >= 0; i--) begin
      send_chip(logic'(16'h6699 >> i));
      if (i > 0) begin
        idle(1);
        check("stall_no_strobe", {31'd0, rx_word_valid}, 32'd0);
      end
    end
    rx_serial_valid = 1'b0;
    check("stall_word_valid", {31'd0, rx_word_valid}, 32'd1);
    idle(2);

    // rx_en dropped on the 16th chip discards the word.
    for (int i = 15; i >= 1; i--) send_chip(logic'(16'h6699 >> i));
    rx_en = 1'b0;
    send_chip(1'b1);
    rx_serial_valid = 1'b0;
    check("en_drop_no_strobe", {31'd0, rx_word_valid}, 32'd0);
    check("en_drop_unlocked", {31'd0, rx_locked}, 32'd0);
    check("en_drop_count_held", {24'd0, rx_err_count}, 32'd5);
    rx_en = 1'b1;
    idle(2);

    // Clear beats a simultaneous increment.
    send_word(16'h9AA5);
    check("relock2", {31'd0, rx_locked}, 32'd1);
    push(8'h5A, 1'b1, 1'b0);
    for (int i = 15; i >= 1; i--) send_chip(logic'(16'h6698 >> i));
    rx_err_clr = 1'b1;
    send_chip(1'b0);
    rx_err_clr = 1'b0;
    rx_serial_valid = 1'b0;
    check("clr_wins", {24'd0, rx_err_count}, 32'd0);

    // Sync byte while locked.
`ifndef SERDESPHY_RX_SYNC_STRIP_EN
    push(8'hBC, 1'b0, 1'b0);
`endif
    push(8'h5A, 1'b0, 1'b0);
    send_word(16'h9AA5);
    send_word(16'h6699);
    check("locked_after_sync_data", {31'd0, rx_locked}, 32'd1);
    idle(2);

    // Reset mid-word.
    for (int i = 0; i < 8; i++) send_chip(1'b1);
    rx_serial_valid = 1'b0;
    rst_n_240m_rx = 1'b0;
    #1;
    check("midword_rst_unlocked", {31'd0, rx_locked}, 32'd0);
    idle(2);
    rst_n_240m_rx = 1'b1;
    idle(4);
    check("post_rst_no_strobe", {31'd0, rx_word_valid}, 32'd0);

    check("scoreboard_drained", q_exp.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
